// File: rtl/jk_pkg.sv
// Shared JK flip-flop types, the excitation helper and parameter range checks for jk_mod_counter.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_t;

   localparam int JK_MIN_WIDTH   = 1;
   localparam int JK_MAX_WIDTH   = 16;
   localparam int JK_MIN_MODULUS = 2;

   // Returns {J,K}; only hold, set or reset are ever produced, never toggle.
   function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
      return {nxt & ~cur, ~nxt & cur};
   endfunction

   function automatic bit jk_modulus_ok(input int width, input int modulus);
      return (width >= JK_MIN_WIDTH) && (width <= JK_MAX_WIDTH) &&
             (modulus >= JK_MIN_MODULUS) && (modulus <= (1 << width));
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single behavioural JK flip-flop with asynchronous active-high reset.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg <= 1'b0;
      end else begin
         case (jk_op_t'({j, k}))
            JK_HOLD:   q_reg <= q_reg;
            JK_RESET:  q_reg <= 1'b0;
            JK_SET:    q_reg <= 1'b1;
            JK_TOGGLE: q_reg <= ~q_reg;
            default:   q_reg <= q_reg;
         endcase
      end
   end

   assign q    = q_reg;
   assign qbar = ~q_reg;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from per-bit JK cells with a registered terminal-count pulse.
// Define JK_COUNTER_SAT_EN for saturating mode instead of wrap-around.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc
);

   generate
      if (!jk_modulus_ok(WIDTH, MODULUS)) begin : g_bad_param
         $error("jk_mod_counter: WIDTH/MODULUS out of range");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
`ifdef JK_COUNTER_SAT_EN
   localparam logic [WIDTH-1:0] NEAR_TOP = WIDTH'(MODULUS - 2);
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
`endif

   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;
   logic             tc_next;
   logic             tc_reg;

   always_comb begin
      count_next = q;
      tc_next    = 1'b0;
      if (load) begin
         count_next = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
      end else if (en) begin
         if (up) begin
            if (q == MAX_VAL) begin
`ifdef JK_COUNTER_SAT_EN
               count_next = MAX_VAL;
`else
               count_next = '0;
               tc_next    = 1'b1;
`endif
            end else begin
               count_next = q + 1'b1;
`ifdef JK_COUNTER_SAT_EN
               tc_next    = (q == NEAR_TOP);
`endif
            end
         end else begin
            if (q == '0) begin
`ifdef JK_COUNTER_SAT_EN
               count_next = '0;
`else
               count_next = MAX_VAL;
               tc_next    = 1'b1;
`endif
            end else begin
               count_next = q - 1'b1;
`ifdef JK_COUNTER_SAT_EN
               tc_next    = (q == ONE_VAL);
`endif
            end
         end
      end
   end

   // The count state lives only in the JK cells; this block just steers J/K.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign {j_vec[gi], k_vec[gi]} = jk_excite(q[gi], count_next[gi]);

         jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (j_vec[gi]),
            .k    (k_vec[gi]),
            .q    (q[gi]),
            .qbar (qbar[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tc_reg <= 1'b0;
      end else begin
         tc_reg <= tc_next;
      end
   end

   assign tc = tc_reg;

endmodule
